// File: rtl/vdac_out.sv
// ---------------------------------------------------------------------------
// vdac_out
//
// Output stage between the colour LUT (ide_video) and the VDAC. It registers
// the 8-bit RGB in two stages (S1, S2) and delays hsync/vsync/blank by the
// same two cycles so control stays aligned with the pixels. RGB is forced to
// black during blanking and while the mode-change mute is active.
//
// It also owns the LUT mode select. A requested mode change is held pending
// until the next vsync leading edge, applied in the cycle after that edge,
// and then followed by MUTE_FRAMES frames of black output.
//
// Optional build macro:
//   VDAC_TESTPAT_EN  adds a pixel counter and an 8-bar colour test pattern
//                    selected by test_en. Without it test_en is ignored.
//
// Ports:
//   clk                    pixel clock
//   rst                    synchronous reset, active high
//   mode_req               requested LUT mode (0 = LUT, 1 = linear)
//   mode                   applied LUT mode, drives ide_video.mode
//   v_r_in/v_g_in/v_b_in   8-bit RGB from ide_video
//   hsync_in/vsync_in      syncs aligned with the incoming RGB
//   blank_in               1 = blanking interval, aligned with the RGB
//   test_en                test-pattern enable (VDAC_TESTPAT_EN only)
//   v_r/v_g/v_b            registered RGB to the VDAC (2-cycle latency)
//   hsync/vsync            registered syncs to the VDAC (2-cycle latency)
//   blank_n                registered active-low blank (2-cycle latency)
//   muted                  1 while the mode-change mute is active
// ---------------------------------------------------------------------------
module vdac_out #(
    parameter logic        HSYNC_POL   = 1'b0,
    parameter logic        VSYNC_POL   = 1'b0,
    parameter int unsigned MUTE_FRAMES = 1,     // 0..15, 0 = no mute
    parameter int unsigned BAR_W       = 80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_req,
    output logic       mode,
    input  logic [7:0] v_r_in,
    input  logic [7:0] v_g_in,
    input  logic [7:0] v_b_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       blank_in,
    input  logic       test_en,
    output logic [7:0] v_r,
    output logic [7:0] v_g,
    output logic [7:0] v_b,
    output logic       hsync,
    output logic       vsync,
    output logic       blank_n,
    output logic       muted
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_MUTE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // Mode-change control
    // -----------------------------------------------------------------------
    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               vs_prev_q, vs_prev_d;
    logic               vs_edge;

    // vs_prev resets to the inactive level, so a vsync that is already active
    // in the first cycle after reset is seen as a leading edge.
    assign vs_edge   = (vsync_in == VSYNC_POL) && (vs_prev_q != VSYNC_POL);
    assign vs_prev_d = vsync_in;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (mode_req != mode_q) begin
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // A withdrawn request wins over a coincident vsync edge.
                if (mode_req == mode_q) begin
                    state_d = ST_IDLE;
                end else if (vs_edge) begin
                    mode_d = mode_req;
                    if (MUTE_FRAMES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = CNT_W'(MUTE_FRAMES);
                        state_d = ST_MUTE;
                    end
                end
            end
            ST_MUTE: begin
                // Requests arriving during the mute are only looked at on exit.
                if (vs_edge) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = (mode_req != mode_q) ? ST_PEND : ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            cnt_q     <= '0;
            vs_prev_q <= ~VSYNC_POL;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            vs_prev_q <= vs_prev_d;
        end
    end

    // -----------------------------------------------------------------------
    // Optional test pattern source
    // -----------------------------------------------------------------------
`ifdef VDAC_TESTPAT_EN
    logic [10:0] pix_q, pix_d;

    // Counts non-blank pixels since the last blank, saturating at 2047.
    always_comb begin
        if (blank_in) begin
            pix_d = '0;
        end else if (pix_q == 11'h7FF) begin
            pix_d = pix_q;
        end else begin
            pix_d = pix_q + 11'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
        end else begin
            pix_q <= pix_d;
        end
    end

    // Bars in order white, yellow, cyan, green, magenta, red, blue, black.
    // With that order R is set where idx[1]==0, G where idx[2]==0 and
    // B where idx[0]==0. Pixels past the eighth bar are black.
    function automatic logic [23:0] bar_rgb(input logic [10:0] pix);
        logic [2:0]  idx;
        logic        hit;
        logic [31:0] pos;
        logic [23:0] rgb;
        idx = 3'd0;
        hit = 1'b0;
        pos = {21'd0, pix};
        for (int unsigned i = 0; i < 8; i++) begin
            if (pos >= i * BAR_W && pos < (i + 1) * BAR_W) begin
                idx = i[2:0];
                hit = 1'b1;
            end
        end
        if (hit) begin
            rgb = {{8{~idx[1]}}, {8{~idx[2]}}, {8{~idx[0]}}};
        end else begin
            rgb = '0;
        end
        return rgb;
    endfunction
`else
    logic unused_test_en;
    assign unused_test_en = test_en;
    localparam int unsigned unused_bar_w = BAR_W;
`endif

    // -----------------------------------------------------------------------
    // Stage S1: capture pixel and control
    // -----------------------------------------------------------------------
    logic [7:0] r_p1_q, r_p1_d;
    logic [7:0] g_p1_q, g_p1_d;
    logic [7:0] b_p1_q, b_p1_d;
    logic       hs_p1_q, hs_p1_d;
    logic       vs_p1_q, vs_p1_d;
    logic       blank_p1_q, blank_p1_d;

    always_comb begin
        r_p1_d     = v_r_in;
        g_p1_d     = v_g_in;
        b_p1_d     = v_b_in;
`ifdef VDAC_TESTPAT_EN
        if (test_en) begin
            {r_p1_d, g_p1_d, b_p1_d} = bar_rgb(pix_q);
        end
`endif
        hs_p1_d    = hsync_in;
        vs_p1_d    = vsync_in;
        blank_p1_d = blank_in;
    end

    // Pixel data needs no reset: S1 blank resets to 1, so S2 masks it.
    always_ff @(posedge clk) begin
        r_p1_q <= r_p1_d;
        g_p1_q <= g_p1_d;
        b_p1_q <= b_p1_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_p1_q    <= ~HSYNC_POL;
            vs_p1_q    <= ~VSYNC_POL;
            blank_p1_q <= 1'b1;
        end else begin
            hs_p1_q    <= hs_p1_d;
            vs_p1_q    <= vs_p1_d;
            blank_p1_q <= blank_p1_d;
        end
    end

    // -----------------------------------------------------------------------
    // Stage S2: black forcing and VDAC output registers
    // -----------------------------------------------------------------------
    logic [7:0] v_r_q, v_r_d;
    logic [7:0] v_g_q, v_g_d;
    logic [7:0] v_b_q, v_b_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       blank_n_q, blank_n_d;
    logic       force_blk;

    // Mute uses the live FSM state, so black starts two cycles after the
    // vsync edge that enters MUTE, one cycle after muted rises.
    assign force_blk = blank_p1_q || (state_q == ST_MUTE);

    always_comb begin
        v_r_d     = force_blk ? 8'd0 : r_p1_q;
        v_g_d     = force_blk ? 8'd0 : g_p1_q;
        v_b_d     = force_blk ? 8'd0 : b_p1_q;
        hsync_d   = hs_p1_q;
        vsync_d   = vs_p1_q;
        blank_n_d = ~blank_p1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v_r_q     <= '0;
            v_g_q     <= '0;
            v_b_q     <= '0;
            hsync_q   <= ~HSYNC_POL;
            vsync_q   <= ~VSYNC_POL;
            blank_n_q <= 1'b0;
        end else begin
            v_r_q     <= v_r_d;
            v_g_q     <= v_g_d;
            v_b_q     <= v_b_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            blank_n_q <= blank_n_d;
        end
    end

    assign v_r     = v_r_q;
    assign v_g     = v_g_q;
    assign v_b     = v_b_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;
    assign blank_n = blank_n_q;
    assign mode    = mode_q;
    assign muted   = (state_q == ST_MUTE);

endmodule
